// File: rtl/boot_loader.sv
// boot_loader: streams a length-prefixed program image into the CPU's unified
// memory, verifies an XOR checksum, then sequences the CPU's reset and run.
// Byte stream format: N (word count), 4*N data bytes little-endian, checksum.
module boot_loader #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 32,
    parameter int MAX_WORDS      = 64,
    parameter int RELEASE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_reset,
    output logic              cpu_run,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [6:0]        words_loaded
);

    localparam int RC_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_DATA, S_WRITE, S_CHECK, S_RELEASE, S_RUN, S_ERROR
    } state_t;

    state_t            state;
    logic [6:0]        n_words;
    logic [1:0]        byte_cnt;
    logic [7:0]        checksum;
    logic [DATA_W-1:0] word_buf;
    logic [RC_W-1:0]   rel_cnt;
    logic              accept;

    // A byte moves only when both sides agree; rx_ready is a register.
    assign accept = rx_valid && rx_ready;

    // Loader FSM; every output is registered and updated on state transitions.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_IDLE;
            n_words      <= '0;
            byte_cnt     <= '0;
            checksum     <= '0;
            word_buf     <= '0;
            rel_cnt      <= '0;
            rx_ready     <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            cpu_reset    <= 1'b1;
            cpu_run      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            case (state)
                // Idle, finished and failed states all accept a new load.
                S_IDLE, S_RUN, S_ERROR: begin
                    if (start) begin
                        state        <= S_COUNT;
                        words_loaded <= '0;
                        checksum     <= '0;
                        byte_cnt     <= '0;
                        rx_ready     <= 1'b1;
                        cpu_reset    <= 1'b1;
                        cpu_run      <= 1'b0;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                    end
                end
                S_COUNT: begin
                    if (accept) begin
                        if (rx_data == 8'd0 || 32'(rx_data) > MAX_WORDS) begin
                            state    <= S_ERROR;
                            rx_ready <= 1'b0;
                            busy     <= 1'b0;
                            error    <= 1'b1;
                        end else begin
                            state   <= S_DATA;
                            n_words <= 7'(rx_data);
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        // Shift in from the top so the first byte ends up in [7:0].
                        checksum <= checksum ^ rx_data;
                        word_buf <= {rx_data, word_buf[DATA_W-1:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state     <= S_WRITE;
                            rx_ready  <= 1'b0;
                            mem_we    <= 1'b1;
                            mem_addr  <= ADDR_W'({words_loaded, 2'b00});
                            mem_wdata <= {rx_data, word_buf[DATA_W-1:8]};
                        end
                    end
                end
                S_WRITE: begin
                    mem_we       <= 1'b0;
                    rx_ready     <= 1'b1;
                    words_loaded <= words_loaded + 7'd1;
                    state        <= (words_loaded + 7'd1 == n_words) ? S_CHECK : S_DATA;
                end
                S_CHECK: begin
                    if (accept) begin
                        rx_ready <= 1'b0;
                        if (rx_data == checksum) begin
                            state   <= S_RELEASE;
                            rel_cnt <= RC_W'(RELEASE_CYCLES);
                        end else begin
                            state <= S_ERROR;
                            busy  <= 1'b0;
                            error <= 1'b1;
                        end
                    end
                end
                S_RELEASE: begin
                    // Run is registered, so leaving on count 1 lands exactly
                    // RELEASE_CYCLES cycles after the checksum was accepted.
                    if (rel_cnt <= RC_W'(1)) begin
                        state     <= S_RUN;
                        cpu_reset <= 1'b0;
                        cpu_run   <= 1'b1;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        rel_cnt <= rel_cnt - RC_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: normal load, bad checksum and recovery,
// gapped stream, bad counts, maximum count, reset mid-load, reload from run.
module tb_boot_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_reset, cpu_run, busy, done, error;
    logic [6:0]  words_loaded;

    int checks = 0;
    int errors = 0;

    logic [7:0]  wa[$];
    logic [31:0] wd[$];

    boot_loader dut (
        .clk(clk), .reset(reset), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset), .cpu_run(cpu_run),
        .busy(busy), .done(done), .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Holds the byte until it is accepted; gap inserts one idle cycle first.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t;
        if (gap) begin
            rx_valid = 1'b0;
            rx_data  = 8'hFF;
            tick();
        end
        rx_data  = b;
        rx_valid = 1'b1;
        t = 0;
        while (!rx_ready && t < 50) begin
            tick();
            t++;
        end
        if (!rx_ready) chk("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'hA5;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
    endtask

    // Write log plus per-cycle invariants.
    always @(negedge clk) begin
        if (reset) begin
            if (mem_we) begin
                wa.push_back(mem_addr);
                wd.push_back(mem_wdata);
                chk("rx_ready_in_write", {31'd0, rx_ready}, 32'd0);
            end
            if (cpu_reset && cpu_run) chk("reset_and_run", 32'd1, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("rst_cpu_run", {31'd0, cpu_run}, 32'd0);
        chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("rst_flags", {29'd0, busy, done, error}, 32'd0);
        chk("rst_mem", {23'd0, mem_we, mem_addr}, 32'd0);
        reset = 1'b1;
        tick();

        // Normal load N=2, with a start pulse mid-load that must be ignored
        pulse_start();
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_rx_ready", {31'd0, rx_ready}, 32'd1);
        send_byte(8'd2, 0);
        send_word(32'h04030201, 0);
        chk("w0_we", {31'd0, mem_we}, 32'd1);
        chk("w0_addr", {24'd0, mem_addr}, 32'h00);
        chk("w0_data", mem_wdata, 32'h04030201);
        chk("w0_rx_ready", {31'd0, rx_ready}, 32'd0);
        pulse_start();
        chk("busy_start_ignored", {30'd0, busy, error}, 32'd2);
        send_word(32'h08070605, 0);
        chk("w1_addr", {24'd0, mem_addr}, 32'h04);
        chk("w1_data", mem_wdata, 32'h08070605);
        send_byte(8'h08, 0);
        chk("rel0_run", {30'd0, cpu_reset, cpu_run}, 32'd2);
        tick();
        chk("rel1_run", {30'd0, cpu_reset, cpu_run}, 32'd2);
        tick();
        chk("run_reset_run", {30'd0, cpu_reset, cpu_run}, 32'd1);
        chk("run_flags", {29'd0, busy, done, error}, 32'd2);
        chk("run_words", {25'd0, words_loaded}, 32'd2);
        chk("n1_writes", wa.size(), 32'd2);
        if (wa.size() == 2) begin
            chk("n1_a0", {24'd0, wa[0]}, 32'h00);
            chk("n1_d0", wd[0], 32'h04030201);
            chk("n1_a1", {24'd0, wa[1]}, 32'h04);
            chk("n1_d1", wd[1], 32'h08070605);
        end

        // Reload from RUN: N=1, DEADBEEF, checksum 0x22
        wa.delete(); wd.delete();
        pulse_start();
        chk("reload_run", {30'd0, cpu_reset, cpu_run}, 32'd2);
        chk("reload_flags", {29'd0, busy, done, error}, 32'd4);
        chk("reload_words", {25'd0, words_loaded}, 32'd0);
        send_byte(8'd1, 0);
        send_word(32'hDEADBEEF, 0);
        chk("reload_addr", {24'd0, mem_addr}, 32'h00);
        chk("reload_data", mem_wdata, 32'hDEADBEEF);
        send_byte(8'h22, 0);
        tick(); tick();
        chk("reload_resume", {30'd0, cpu_reset, cpu_run}, 32'd1);
        chk("reload_writes", wa.size(), 32'd1);

        // Bad checksum
        pulse_start();
        send_byte(8'd2, 0);
        send_word(32'h04030201, 0);
        send_word(32'h08070605, 0);
        send_byte(8'h09, 0);
        chk("badck_flags", {29'd0, busy, done, error}, 32'd1);
        chk("badck_run", {30'd0, cpu_reset, cpu_run}, 32'd2);
        tick();
        chk("badck_hold", {30'd0, cpu_reset, cpu_run}, 32'd2);

        // Recovery with rx_valid toggling every cycle
        wa.delete(); wd.delete();
        pulse_start();
        chk("recover_error_clr", {31'd0, error}, 32'd0);
        send_byte(8'd2, 1);
        send_word(32'h04030201, 1);
        send_word(32'h08070605, 1);
        send_byte(8'h08, 1);
        tick(); tick();
        chk("gap_done", {29'd0, busy, done, error}, 32'd2);
        chk("gap_run", {31'd0, cpu_run}, 32'd1);
        chk("gap_writes", wa.size(), 32'd2);
        if (wa.size() == 2) begin
            chk("gap_d0", wd[0], 32'h04030201);
            chk("gap_a1", {24'd0, wa[1]}, 32'h04);
            chk("gap_d1", wd[1], 32'h08070605);
        end

        // Bad counts: 0 and MAX_WORDS+1
        wa.delete(); wd.delete();
        pulse_start();
        send_byte(8'd0, 0);
        chk("n0_error", {29'd0, busy, done, error}, 32'd1);
        chk("n0_rx_ready", {31'd0, rx_ready}, 32'd0);
        pulse_start();
        send_byte(8'd65, 0);
        chk("n65_error", {29'd0, busy, done, error}, 32'd1);
        tick();
        chk("badn_no_write", wa.size(), 32'd0);

        // Maximum count fills the whole byte-address space
        pulse_start();
        send_byte(8'd64, 0);
        for (int i = 0; i < 64; i++) begin
            logic [7:0] b;
            b = i[7:0];
            send_word({b, b, b, b}, 0);
        end
        send_byte(8'h00, 0);
        tick(); tick();
        chk("max_done", {29'd0, busy, done, error}, 32'd2);
        chk("max_words", {25'd0, words_loaded}, 32'd64);
        chk("max_writes", wa.size(), 32'd64);
        if (wa.size() == 64) begin
            chk("max_a1", {24'd0, wa[1]}, 32'h04);
            chk("max_a63", {24'd0, wa[63]}, 32'hFC);
            chk("max_d63", wd[63], 32'h3F3F3F3F);
        end

        // Reset in the middle of word 0
        wa.delete(); wd.delete();
        pulse_start();
        send_byte(8'd2, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("mid_rst_run", {30'd0, cpu_reset, cpu_run}, 32'd2);
        chk("mid_rst_flags", {29'd0, busy, done, error}, 32'd0);
        chk("mid_rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("mid_rst_mem", {23'd0, mem_we, mem_addr}, 32'd0);
        chk("mid_rst_wdata", mem_wdata, 32'd0);
        chk("mid_rst_words", {25'd0, words_loaded}, 32'd0);
        rx_data  = 8'h33;
        rx_valid = 1'b1;
        tick(); tick();
        rx_valid = 1'b0;
        chk("idle_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("idle_flags", {29'd0, busy, done, error}, 32'd0);
        chk("idle_no_write", wa.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Upstream stage of multi_cycle_CPU. Loads a program image from a byte stream into the CPU's unified instruction/data memory.
- Drives the CPU's active-high RESET and its RUN enable, replacing testbench-style initial sequencing.
- Holds the CPU in reset while loading, verifies an XOR checksum, then releases reset and asserts run.

Parameters:
ADDR_W, 8, memory byte-address width
DATA_W, 32, memory word width (fixed: 4 bytes per word)
MAX_WORDS, 64, largest accepted word count
RELEASE_CYCLES, 2, cycles cpu_reset stays high after a good checksum

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low block reset
start  in  1  one-cycle pulse; begins a load (ignored unless IDLE, DONE or ERROR)
rx_data  in  8  incoming byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  loader accepts byte this cycle
mem_we  out  1  memory write strobe, one cycle per word
mem_addr  out  ADDR_W  byte address of word being written (word_index*4)
mem_wdata  out  DATA_W  assembled word
cpu_reset  out  1  active-high CPU reset (to RESET)
cpu_run  out  1  CPU run enable (to RUN)
busy  out  1  load in progress
done  out  1  load succeeded, CPU running
error  out  1  load failed
words_loaded  out  7  words written in current/last load

Behaviour:
- Byte transfer occurs on a rising edge when rx_valid && rx_ready. rx_data/rx_valid sampled only then.
- rx_ready is 1 only in COUNT, DATA, CHECK. It is registered, so it is never combinationally dependent on rx_valid.
- Reset (reset==0 at an edge, any state):
  - State goes to IDLE.
  - cpu_reset=1, cpu_run=0, rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - busy=0, done=0, error=0, words_loaded=0; checksum and byte counters cleared.
  - Reset mid-load abandons the load; partially written memory is not rolled back.
- States:
  - IDLE: cpu_reset=1. start moves to COUNT; clears words_loaded and checksum; error=0, done=0, busy=1.
  - COUNT: accept one byte N.
    - N==0 or N>MAX_WORDS goes to ERROR.
    - Otherwise latch N and go to DATA.
  - DATA: accept bytes little-endian; the first byte of a word is bits [7:0].
    - Every accepted byte is XORed into the checksum.
    - After the 4th byte go to WRITE.
  - WRITE: exactly one cycle.
    - mem_we=1, mem_addr=words_loaded*4 (truncated to ADDR_W), mem_wdata=assembled word.
    - words_loaded increments at the end of this cycle.
    - If the new count equals N go to CHECK, else back to DATA.
    - rx_ready=0 here.
  - CHECK: accept one byte.
    - If it equals the checksum, go to RELEASE with counter=RELEASE_CYCLES.
    - Else go to ERROR.
  - RELEASE: cpu_reset=1; counter decrements each cycle. At 0 go to RUN.
  - RUN: cpu_reset=0, cpu_run=1, done=1, busy=0.
    - start here returns to COUNT with cpu_reset=1, cpu_run=0 on the next cycle (reload).
  - ERROR: cpu_reset=1, cpu_run=0, error=1, busy=0. start goes to COUNT.
- cpu_reset and cpu_run are never both 1. cpu_run rises in the same cycle cpu_reset falls.
- mem_we is high only in WRITE. mem_addr/mem_wdata hold their last values otherwise.
- start while busy (COUNT..RELEASE) is ignored.
- Latency: last data byte accepted at edge k, mem_we high in cycle k+1. Checksum byte accepted at edge j, cpu_run=1 from cycle j+RELEASE_CYCLES+1.
- Address wrap: with MAX_WORDS*4 > 2^ADDR_W, addresses wrap modulo 2^ADDR_W. The default (64*4=256) exactly fills 8-bit space without wrap.

Test Plan:
- Reset then start, stream N=2, bytes 01 02 03 04 05 06 07 08, checksum 0x08 -> exactly two writes: mem_addr 0x00 data 0x04030201, then 0x04 data 0x08070605. words_loaded=2. cpu_run=1, cpu_reset=0 two cycles after checksum accept. done=1.
- Same stream with checksum 0x09 -> error=1, cpu_reset stays 1, cpu_run=0. A following start plus a correct stream recovers to done=1.
- N=0 and separately N=65 -> ERROR right after count byte; no mem_we pulse.
- rx_valid toggled 1/0 every cycle during DATA -> only handshaked bytes counted. Written words identical to the no-gap case. rx_ready=0 during each WRITE cycle.
- Assert reset low for one cycle in the middle of word 1 -> all outputs at reset values next cycle. State IDLE; subsequent bytes ignored (rx_ready=0) until start.
- In RUN pulse start, then load N=1 data DEADBEEF LE (EF BE AD DE), checksum 0x22 -> cpu_run drops the cycle after start. Write at 0x00 = 0xDEADBEEF. Run resumes after RELEASE.
